// File: rtl/my_mc_ctrl.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/exec/mem/wb for one
// instruction at a time, drives datapath selects/enables and counts retirements.
module my_mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  ImmSel,
    output logic        retire,
    output logic [31:0] instret,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic       supported;
    logic [1:0] imm_sel_dec;

    assign opcode    = instr[6:0];
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_ld     = (opcode == OP_LOAD);
    assign is_st     = (opcode == OP_STORE);
    assign is_br     = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign supported = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

    // R-type has no immediate; I is harmless there.
    always_comb begin
        imm_sel_dec = 2'b00;
        if (is_st)                         imm_sel_dec = 2'b01;
        else if (is_br)                    imm_sel_dec = 2'b10;
        else if (is_jal | is_lui | is_auipc) imm_sel_dec = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        ImmSel    = 2'b00;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ImmSel = imm_sel_dec;
                // Precompute PC+imm into ALUOut for branch and JAL targets.
                if (is_br | is_jal) begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                state_d = supported ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                ImmSel  = imm_sel_dec;
                state_d = S_TRAP;
                if (is_r | is_i) begin
                    alu_src_b = is_i ? 2'b01 : 2'b00;
                    alu_op    = 2'b10;
                    state_d   = S_WB;
                end else if (is_ld | is_st) begin
                    alu_src_b = 2'b01;
                    state_d   = S_MEM;
                end else if (is_br) begin
                    alu_op  = 2'b01;
                    pc_we   = 1'b1;
                    pc_src  = br_taken ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jal | is_jalr) begin
                    reg_we  = 1'b1;
                    wb_sel  = 2'b10;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    if (is_jalr) begin
                        alu_src_b = 2'b01;
                        pc_src    = 2'b10;
                    end else begin
                        pc_src    = 2'b01;
                    end
                end else if (is_lui) begin
                    state_d = S_WB;
                end else if (is_auipc) begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    state_d   = S_WB;
                end
            end
            S_MEM: begin
                ImmSel   = imm_sel_dec;
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_st;
                if (mem_ready) begin
                    if (is_st) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                ImmSel  = imm_sel_dec;
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                wb_sel  = is_ld ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
                state_d = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_RESET;
        endcase
    end

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule
